// File: rtl/data_mem_resp_if.sv
// Load/store port between the MIPS datapath (master) and the data-memory responder (slave).
interface data_mem_resp_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_size, mem_unsigned,
    input  mem_rdata, mem_ready, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_size, mem_unsigned,
    output mem_rdata, mem_ready, mem_err
  );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: word RAM with programmable wait states, byte/half/word
// little-endian accesses, sign/zero-extended loads and access error flagging.
module data_mem_resp #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  data_mem_resp_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;

  // Request captured at accept
  logic           a_we;
  logic [31:0]    a_addr;
  logic [31:0]    a_wdata;
  logic [1:0]     a_size;
  logic           a_uns;

  logic [31:0]    ram [DEPTH];

  // Effective request view: live inputs on the accept cycle, captured copy afterwards
  logic           e_we;
  logic [31:0]    e_addr;
  logic [1:0]     e_size;
  logic           e_uns;
  logic           e_err;
  logic [31:0]    e_ldata;
  logic           go_resp;

  logic [31:0]    rword;
  logic [31:0]    rshift;
  logic [15:0]    rhalf;
  logic [3:0]     wbe;
  logic [31:0]    wlane;

  // Pick the request being decided on this cycle
  always_comb begin
    e_we   = a_we;
    e_addr = a_addr;
    e_size = a_size;
    e_uns  = a_uns;
    if (state == IDLE) begin
      e_we   = bus.mem_we;
      e_addr = bus.mem_addr;
      e_size = bus.mem_size;
      e_uns  = bus.mem_unsigned;
    end
  end

  // Size, alignment and range checks
  always_comb begin
    e_err = 1'b0;
    case (e_size)
      2'b11:   e_err = 1'b1;
      2'b01:   e_err = e_addr[0];
      2'b10:   e_err = (e_addr[1:0] != 2'b00);
      default: e_err = 1'b0;
    endcase
    if ({2'b00, e_addr[31:2]} >= DEPTH) e_err = 1'b1;
  end

  // Load lane select and extension
  always_comb begin
    rword   = ram[e_addr[AW+1:2]];
    rshift  = rword >> {e_addr[1:0], 3'b000};
    rhalf   = e_addr[1] ? rword[31:16] : rword[15:0];
    case (e_size)
      2'b00:   e_ldata = {{24{~e_uns & rshift[7]}}, rshift[7:0]};
      2'b01:   e_ldata = {{16{~e_uns & rhalf[15]}}, rhalf};
      default: e_ldata = rword;
    endcase
  end

  // Store byte-enables and lane-replicated write data
  always_comb begin
    case (a_size)
      2'b00: begin
        wbe   = 4'b0001 << a_addr[1:0];
        wlane = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        wbe   = a_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{a_wdata[15:0]}};
      end
      default: begin
        wbe   = 4'b1111;
        wlane = a_wdata;
      end
    endcase
  end

  // Response is launched on the edge that enters RESP
  always_comb begin
    go_resp = 1'b0;
    if (state == IDLE && bus.mem_req && WAIT_STATES == 0) go_resp = 1'b1;
    if (state == WAIT && cnt == '0) go_resp = 1'b1;
  end

  // Control FSM with registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      a_we          <= 1'b0;
      a_addr        <= '0;
      a_wdata       <= '0;
      a_size        <= '0;
      a_uns         <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.mem_err   <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      bus.mem_ready <= 1'b0;
      bus.mem_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_req) begin
            a_we    <= bus.mem_we;
            a_addr  <= bus.mem_addr;
            a_wdata <= bus.mem_wdata;
            a_size  <= bus.mem_size;
            a_uns   <= bus.mem_unsigned;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CW'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        bus.mem_ready <= 1'b1;
        bus.mem_err   <= e_err;
        if (e_err)      bus.mem_rdata <= '0;
        else if (!e_we) bus.mem_rdata <= e_ldata;
      end
    end
  end

  // RAM write on the edge that ends an error-free store response
  always_ff @(posedge clk) begin
    if (state == RESP && a_we && !bus.mem_err) begin
      for (int k = 0; k < 4; k++) begin
        if (wbe[k]) ram[a_addr[AW+1:2]][8*k +: 8] <= wlane[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: one instance with 2 wait states, one with none.
module tb_data_mem_resp;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_asserts = 0;
  int   n_fail = 0;

  data_mem_resp_if b2 ();
  data_mem_resp_if b0 ();

  data_mem_resp #(.DEPTH(256), .WAIT_STATES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  data_mem_resp #(.DEPTH(256), .WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the 2-wait-state instance; called #1 after a rising edge
  task automatic txn2(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    lat = 0;
    b2.mem_req      = 1'b1;
    b2.mem_we       = we;
    b2.mem_addr     = addr;
    b2.mem_wdata    = wdata;
    b2.mem_size     = size;
    b2.mem_unsigned = uns;
    do begin
      @(posedge clk); #1;
      lat++;
      // Scramble inputs after accept; responder must ignore them
      if (lat == 1) begin
        b2.mem_addr  = 32'hFFFF_FFFF;
        b2.mem_wdata = 32'h0;
        b2.mem_we    = ~we;
        b2.mem_size  = 2'b11;
      end
    end while (!b2.mem_ready && lat < 20);
    b2.mem_req = 1'b0;
    check({tag, "_lat"},   32'(lat), 32'd3);
    check({tag, "_err"},   32'(b2.mem_err), 32'(exp_err));
    check({tag, "_rdata"}, b2.mem_rdata, exp_rdata);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {30'd0, b2.mem_ready, b2.mem_err}, 32'd0);
  endtask

  initial begin
    int readies;
    b2.mem_req = 1'b0; b2.mem_we = 1'b0; b2.mem_addr = '0; b2.mem_wdata = '0;
    b2.mem_size = 2'b10; b2.mem_unsigned = 1'b0;
    b0.mem_req = 1'b0; b0.mem_we = 1'b0; b0.mem_addr = '0; b0.mem_wdata = '0;
    b0.mem_size = 2'b10; b0.mem_unsigned = 1'b0;

    #2 rst_n = 1'b0;
    #2;
    check("rst_ready2", 32'(b2.mem_ready), 32'd0);
    check("rst_err2",   32'(b2.mem_err),   32'd0);
    check("rst_rdata2", b2.mem_rdata,      32'd0);
    check("rst_rdata0", b0.mem_rdata,      32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store/load
    txn2("sw10",  1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0000_0000, 1'b0);
    txn2("lw10",  1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
    // Byte store, byte loads
    txn2("sb11",  1'b1, 32'h11, 32'hFFFF_FF5A, 2'b00, 1'b0, 32'hDEADBEEF, 1'b0);
    txn2("lbu11", 1'b0, 32'h11, 32'h0,        2'b00, 1'b1, 32'h0000_005A, 1'b0);
    txn2("lb13",  1'b0, 32'h13, 32'h0,        2'b00, 1'b0, 32'hFFFF_FFDE, 1'b0);
    txn2("lw10b", 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEAD5AEF, 1'b0);
    // Halfword store over a known word, halfword loads
    txn2("sw20",  1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 32'hDEAD5AEF, 1'b0);
    txn2("sh22",  1'b1, 32'h22, 32'hFFFF8001, 2'b01, 1'b0, 32'hDEAD5AEF, 1'b0);
    txn2("lh22",  1'b0, 32'h22, 32'h0,        2'b01, 1'b0, 32'hFFFF8001, 1'b0);
    txn2("lhu22", 1'b0, 32'h22, 32'h0,        2'b01, 1'b1, 32'h0000_8001, 1'b0);
    txn2("lw20",  1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 32'h80013344, 1'b0);
    // Error cases
    txn2("sw0",   1'b1, 32'h0,  32'hCAFEF00D, 2'b10, 1'b0, 32'h80013344, 1'b0);
    txn2("lw12e", 1'b0, 32'h12, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1);
    txn2("lw10c", 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEAD5AEF, 1'b0);
    txn2("lh13e", 1'b0, 32'h13, 32'h0,        2'b01, 1'b0, 32'h0,        1'b1);
    txn2("s11e",  1'b1, 32'h10, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h0,        1'b1);
    txn2("lw10d", 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEAD5AEF, 1'b0);
    txn2("swore", 1'b1, 32'h400, 32'h55555555, 2'b10, 1'b0, 32'h0,       1'b1);
    txn2("lw0",   1'b0, 32'h0,  32'h0,        2'b10, 1'b0, 32'hCAFEF00D, 1'b0);
    txn2("sw30",  1'b1, 32'h30, 32'h0BADF00D, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);

    // Reset during WAIT of a store
    b2.mem_req = 1'b1; b2.mem_we = 1'b1; b2.mem_addr = 32'h30;
    b2.mem_wdata = 32'h12345678; b2.mem_size = 2'b10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    b2.mem_req = 1'b0;
    #1;
    check("mrst_ready", 32'(b2.mem_ready), 32'd0);
    check("mrst_err",   32'(b2.mem_err),   32'd0);
    check("mrst_rdata", b2.mem_rdata,      32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mrst_noready", 32'(b2.mem_ready), 32'd0);
    end
    txn2("lw30", 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 32'h0BADF00D, 1'b0);

    // Zero wait states: request dropped right after accept
    b0.mem_req = 1'b1; b0.mem_we = 1'b1; b0.mem_addr = 32'h8;
    b0.mem_wdata = 32'hA5A5A5A5; b0.mem_size = 2'b10;
    @(posedge clk); #1;
    b0.mem_req = 1'b0;
    check("ws0_ready",  32'(b0.mem_ready), 32'd1);
    check("ws0_err",    32'(b0.mem_err),   32'd0);
    @(posedge clk); #1;
    check("ws0_pulse",  32'(b0.mem_ready), 32'd0);
    @(posedge clk); #1;
    check("ws0_idle",   32'(b0.mem_ready), 32'd0);

    // Zero wait states: continuous loads give one ready every two cycles
    b0.mem_req = 1'b1; b0.mem_we = 1'b0; b0.mem_addr = 32'h8; b0.mem_size = 2'b10;
    readies = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (b0.mem_ready) readies++;
      check("ws0_cont", 32'(b0.mem_ready), 32'(i % 2));
    end
    b0.mem_req = 1'b0;
    check("ws0_count", 32'(readies), 32'd4);
    check("ws0_rdata", b0.mem_rdata, 32'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
